// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue
//   Instruction-fetch front end feeding the IF/ID pipeline register. Issues
//   sequential word-addressed fetches to a variable-latency, in-order memory.
//   Buffers the returned words with their PCs in a FIFO and presents the head.
//   Holds the head under stall. On redirect it flushes and discards every
//   response still owed to pre-redirect requests.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   stall                    hold head entry
//   redirect, redirect_pc    flush and restart fetching at redirect_pc
//   imem_req, imem_addr      fetch request (issued when imem_ready)
//   imem_ready               memory accepts request this cycle
//   imem_rvalid, imem_rdata  in-order response
//   out_valid, out_pc, out_instr  FIFO head for IF/ID
module if_prefetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       WORD_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       MAX_OUT  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_instr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned SW = $clog2(DEPTH + MAX_OUT + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [WORD_W-1:0] instr_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic [ADDR_W-1:0] ipc_mem   [MAX_OUT];
    logic [IW-1:0]     ipc_rd;
    logic [IW-1:0]     ipc_wr;
    logic [ADDR_W-1:0] last_pc;
    logic [WORD_W-1:0] last_instr;
    logic [SW-1:0]     occupancy;
    logic              has_room;
    logic              issue;
    logic              push;
    logic              pop;

    // Slots already committed: buffered words plus responses that will be kept.
    always_comb begin
        occupancy = SW'(count) + SW'(outstanding) - SW'(drop_cnt);
        has_room  = (occupancy < SW'(DEPTH)) && (outstanding < OW'(MAX_OUT));
    end

    assign imem_req  = !rst && !redirect && has_room;
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_ready;
    assign out_valid = (count != '0);
    assign push      = imem_rvalid && (drop_cnt == '0) && !redirect;
    assign pop       = out_valid && !stall && !redirect;

    // While empty the head slot is stale, so show the last value presented.
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : last_pc;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : last_instr;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= ipc_mem[ipc_rd];
            instr_mem[wr_ptr] <= imem_rdata;
        end
        if (issue) begin
            ipc_mem[ipc_wr] <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            ipc_rd      <= '0;
            ipc_wr      <= '0;
            last_pc     <= '0;
            last_instr  <= '0;
        end else begin
            // The issue-PC FIFO tracks every owed response regardless of redirect;
            // after a flush its remaining entries are exactly the ones to drop.
            if (issue) begin
                ipc_wr <= (ipc_wr == IW'(MAX_OUT - 1)) ? '0 : ipc_wr + IW'(1);
            end
            if (imem_rvalid) begin
                ipc_rd <= (ipc_rd == IW'(MAX_OUT - 1)) ? '0 : ipc_rd + IW'(1);
            end
            case ({issue, imem_rvalid})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase

            if (out_valid) begin
                last_pc    <= pc_mem[rd_ptr];
                last_instr <= instr_mem[rd_ptr];
            end

            if (redirect) begin
                // No issue this cycle; a same-cycle response is discarded now.
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outstanding - OW'(imem_rvalid);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                end
                if (imem_rvalid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Testbench for if_prefetch_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference of the fetch front end.
module tb_if_prefetch_queue;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .ADDR_W  (ADDR_W),
        .WORD_W  (WORD_W),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr)
    );

    typedef struct { logic [31:0] pc; logic stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;

    pend_t pend[$];   // reference: requests owed, marked stale by redirect
    ent_t  fifo[$];   // reference: buffered words
    mreq_t memq[$];   // memory model: accepted requests awaiting response

    logic [31:0] m_fetch, next_pc, last_pc, last_instr, last_pop_pc, frz;
    int unsigned cyc, lat, pops, drops;
    int errors = 0;
    int checks = 0;

    logic        c_req, c_ready, c_rvalid, c_redirect, e_req, e_pop;
    logic [31:0] c_addr, c_rdata, c_rpc, c_out_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h100 + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        int unsigned live;
        pend_t p;
        @(negedge clk);
        live = 0;
        foreach (pend[i]) if (!pend[i].stale) live++;
        e_req = !redirect && (pend.size() < MAX_OUT) && (fifo.size() + live < DEPTH);
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_fetch);
        chk("out_valid", out_valid, fifo.size() != 0);
        if (fifo.size() != 0) begin
            chk("out_pc", out_pc, fifo[0].pc);
            chk("out_instr", out_instr, fifo[0].instr);
            last_pc    = fifo[0].pc;
            last_instr = fifo[0].instr;
        end else begin
            chk("out_pc_hold", out_pc, last_pc);
            chk("out_instr_hold", out_instr, last_instr);
        end
        chk("outstanding_le_max", memq.size() <= MAX_OUT, 1);
        e_pop = (fifo.size() != 0) && !stall && !redirect;
        if (e_pop) begin
            chk("stream_pc", out_pc, next_pc);
            last_pop_pc = out_pc;
            next_pc     = next_pc + 32'd1;
            pops++;
        end
        c_req = imem_req; c_addr = imem_addr; c_ready = imem_ready;
        c_rvalid = imem_rvalid; c_rdata = imem_rdata; c_redirect = redirect;
        c_rpc = redirect_pc; c_out_pc = out_pc;

        @(posedge clk);
        #1;
        if (c_rvalid && memq.size() != 0) memq.delete(0);
        if (c_req && c_ready) memq.push_back('{c_addr, cyc + lat});
        cyc++;

        if (c_redirect) begin
            fifo.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            if (c_rvalid && pend.size() != 0) begin
                pend.delete(0);
                drops++;
            end
            m_fetch = c_rpc;
            next_pc = c_rpc;
        end else begin
            if (e_pop) fifo.delete(0);
            if (c_rvalid && pend.size() != 0) begin
                p = pend[0];
                pend.delete(0);
                if (p.stale) drops++;
                else fifo.push_back('{p.pc, c_rdata});
            end
            if (e_req && c_ready) begin
                pend.push_back('{m_fetch, 1'b0});
                m_fetch = m_fetch + 32'd1;
            end
        end

        if (memq.size() != 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(memq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        memq.delete(); pend.delete(); fifo.delete();
        m_fetch = RESET_PC; next_pc = RESET_PC;
        last_pc = '0; last_instr = '0; cyc = 0;
        rst = 1'b0;
    endtask

    task automatic wait_pop(input int unsigned budget);
        int unsigned p0;
        p0 = pops;
        for (int unsigned i = 0; i < budget && pops == p0; i++) cycle();
        chk("pop_within_budget", pops != p0, 1);
    endtask

    initial begin
        pops = 0; drops = 0; lat = 1;
        do_reset();

        // Single-cycle memory, no stall: one instruction per cycle after 2-cycle fill.
        imem_ready = 1'b1;
        repeat (12) cycle();
        chk("t1_pops", pops, 10);

        // Stall: head frozen, requests stop once buffered+owed reaches DEPTH.
        stall = 1'b1;
        cycle();
        frz = c_out_pc;
        repeat (5) cycle();
        chk("t2_frozen_pc", c_out_pc, frz);
        chk("t2_req_low", c_req, 0);
        stall = 1'b0;
        repeat (10) cycle();

        // Redirect with exactly two requests outstanding.
        lat = 3;
        do_reset();
        imem_ready = 1'b1;
        for (int unsigned i = 0; i < 20 && memq.size() != 2; i++) cycle();
        chk("t3_two_outstanding", memq.size(), 2);
        drops = 0;
        redirect = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect = 1'b0;
        wait_pop(40);
        chk("t3_first_pc", last_pop_pc, 32'h40);
        chk("t3_dropped", drops, 2);

        // Back-to-back redirects: the later one wins.
        repeat (8) cycle();
        redirect = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_pc = 32'h80;
        cycle();
        redirect = 1'b0;
        wait_pop(40);
        chk("t4_first_pc", last_pop_pc, 32'h80);

        // Ready toggling with 3-cycle latency.
        for (int unsigned i = 0; i < 60; i++) begin
            imem_ready = ~imem_ready;
            cycle();
        end

        // Address wrap, then asynchronous reset mid-stream.
        lat = 1; imem_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cycle();
        redirect = 1'b0;
        wait_pop(40);
        chk("t6_top_pc", last_pop_pc, 32'hFFFF_FFFF);
        wait_pop(10);
        chk("t6_wrapped_pc", last_pop_pc, 32'h0);
        repeat (4) cycle();
        chk("t6_pre_rst_valid", c_out_pc, next_pc - 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_imem_req", imem_req, 0);
        do_reset();

        // Random traffic.
        for (int unsigned b = 0; b < 8; b++) begin
            lat = $urandom_range(1, 4);
            for (int unsigned i = 0; i < 60; i++) begin
                imem_ready  = ($urandom_range(0, 3) != 0);
                stall       = ($urandom_range(0, 3) == 0);
                redirect    = ($urandom_range(0, 15) == 0);
                redirect_pc = $urandom;
                cycle();
            end
        end
        redirect = 1'b0; stall = 1'b0;
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
